leaf_stream_fifo: RTL

LEAF_STREAM_FIFO -- requirements
Module: leaf_stream_fifo

---
 rtl/leaf_stream_fifo.sv | 71 +++++++
 1 files changed

// File: rtl/leaf_stream_fifo.sv
// leaf_stream_fifo: single-clock ready/valid stream FIFO.
//   Registered in_ready (no out_ready -> in_ready path), no write-to-read
//   bypass, head word read combinationally from storage at rd_ptr.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake, in_data write word
//   out_valid/out_ready downstream handshake, out_data head word
//   count               occupied entries (0..DEPTH)
//   full, empty         count == DEPTH / count == 0
module leaf_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             wr, rd;

  // Status derives from the count register only, so in_ready has no
  // combinational dependency on out_ready.
  assign full      = (cnt == CNT_FULL);
  assign empty     = (cnt == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
  assign count     = cnt;

  assign wr = in_valid && in_ready;
  assign rd = out_valid && out_ready;

  // Storage is intentionally not reset; contents are only observed through
  // out_valid, which reset forces low.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= in_data;
  end

  // DEPTH is a power of two, so natural pointer overflow gives modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
